// File: rtl/multiplier_iterative.sv
// multiplier_iterative: multi-cycle shift-add multiplier retiring R multiplier
// bits per clock (W/R iterations per product), signed or unsigned per
// operation, valid/ready handshake on operand and result sides.
// Optional feature macro: MULT_ACC_EN adds the acc_clr port and a 2W-bit
// accumulator that sums products across DONE handshakes (wraps mod 2^(2W)).
module multiplier_iterative #(
  parameter int W = 32,
  parameter int R = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
`ifdef MULT_ACC_EN
  ,
  input  logic           acc_clr
`endif
);

  localparam int N  = W / R;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (W < 2 || R < 1 || R > W || (W % R) != 0) begin : g_param_check
    $error("multiplier_iterative: W must be >= 2 and a multiple of R (1 <= R <= W)");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [2*W-1:0] r_mcand;    // |a| pre-shifted to the weight of the current digit
  logic [W-1:0]   r_mplier;   // |b|, consumed R bits at a time from the bottom
  logic [2*W-1:0] r_partial;
  logic           r_neg;
  logic [CW-1:0]  r_cnt;

  logic           w_accept;
  logic           w_last;
  logic [W-1:0]   w_a_mag;
  logic [W-1:0]   w_b_mag;
  logic [2*W-1:0] w_pp;
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_result;

  // Magnitudes; -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned value.
  assign w_a_mag = (is_signed && a[W-1]) ? -a : a;
  assign w_b_mag = (is_signed && b[W-1]) ? -b : b;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_cnt == LAST);
  assign w_pp     = r_mcand * {{(2*W-R){1'b0}}, r_mplier[R-1:0]};
  assign w_prod   = r_neg ? -r_partial : r_partial;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture on accept, one shift-add digit per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_partial <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_mcand   <= {{W{1'b0}}, w_a_mag};
      r_mplier  <= w_b_mag;
      r_partial <= '0;
      r_neg     <= is_signed & (a[W-1] ^ b[W-1]);
      r_cnt     <= '0;
    end else if (r_state == S_RUN) begin
      r_partial <= r_partial + w_pp;
      r_mcand   <= r_mcand << R;
      r_mplier  <= r_mplier >> R;
      r_cnt     <= r_cnt + CW'(1);
    end
  end

`ifdef MULT_ACC_EN
  logic [2*W-1:0] r_acc;
  logic           r_acc_clr;

  assign w_result = (r_acc_clr ? '0 : r_acc) + w_prod;

  // Accumulator commits only when the consumer takes the result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_acc_clr <= 1'b0;
    end else begin
      if (w_accept)              r_acc_clr <= acc_clr;
      if (out_valid & out_ready) r_acc     <= w_result;
    end
  end
`else
  assign w_result = w_prod;
`endif

  assign p = out_valid ? w_result : '0;

endmodule
